// File: rtl/clk_rec_lock_ctrl.sv
// Lock controller for the clock-recovery datapath: steps through acquisition,
// tracking and lock, adjusts the minimum-interval estimate, and recovers from lost edges.
module clk_rec_lock_ctrl #(
    parameter int CLK_LEN    = 32,
    parameter int ACQ_EDGES  = 16,
    parameter int LOCK_EDGES = 8,
    parameter int BUMP_EDGES = 16,
    parameter int MISS_LIMIT = 3,
    parameter int TIMEOUT    = 300000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               edge_valid,
    input  logic [CLK_LEN-1:0] interval,
    input  logic [CLK_LEN-1:0] clk_freq,
    output logic               freq_reset,
    output logic               freq_bump,
    output logic               out_enable,
    output logic               locked,
    output logic [1:0]         state,
    output logic [7:0]         err_count
);

    localparam int CW  = 16;
    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   acq_cnt_reg;
    logic [CW-1:0]   stable_cnt_reg;
    logic [CW-1:0]   bump_cnt_reg;
    logic [CW-1:0]   miss_cnt_reg;
    logic [WDW-1:0]  wd_reg;
    logic [7:0]      err_reg;
    logic            freq_reset_reg;
    logic            freq_bump_reg;
    logic            out_enable_reg;
    logic            locked_reg;

    // One extra bit keeps the threshold subtraction and compare free of wrap.
    logic [CLK_LEN:0] thresh;
    logic             good_edge;
    logic             wd_expire;

    assign thresh    = {1'b0, clk_freq} - {1'b0, (clk_freq >> 3)};
    assign good_edge = ({1'b0, interval} >= thresh);
    // An edge arriving on the expiry cycle wins, so expiry only fires edge-free.
    assign wd_expire = (state_reg != ST_IDLE) && !edge_valid &&
                       (wd_reg == WDW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            acq_cnt_reg    <= '0;
            stable_cnt_reg <= '0;
            bump_cnt_reg   <= '0;
            miss_cnt_reg   <= '0;
            wd_reg         <= '0;
            err_reg        <= '0;
            freq_reset_reg <= 1'b0;
            freq_bump_reg  <= 1'b0;
            out_enable_reg <= 1'b0;
            locked_reg     <= 1'b0;
        end else begin
            freq_reset_reg <= 1'b0;
            freq_bump_reg  <= 1'b0;
            if (abort) begin
                state_reg      <= ST_IDLE;
                acq_cnt_reg    <= '0;
                stable_cnt_reg <= '0;
                bump_cnt_reg   <= '0;
                miss_cnt_reg   <= '0;
                wd_reg         <= '0;
                out_enable_reg <= 1'b0;
                locked_reg     <= 1'b0;
            end else if (state_reg == ST_IDLE) begin
                wd_reg <= '0;
                if (start) begin
                    state_reg      <= ST_ACQUIRE;
                    freq_reset_reg <= 1'b1;
                end
            end else if (wd_expire) begin
                state_reg      <= ST_ACQUIRE;
                freq_reset_reg <= 1'b1;
                wd_reg         <= '0;
                acq_cnt_reg    <= '0;
                stable_cnt_reg <= '0;
                bump_cnt_reg   <= '0;
                miss_cnt_reg   <= '0;
                out_enable_reg <= 1'b0;
                locked_reg     <= 1'b0;
                if (state_reg != ST_ACQUIRE && err_reg != 8'hFF)
                    err_reg <= err_reg + 8'd1;
            end else if (edge_valid) begin
                wd_reg <= '0;
                case (state_reg)
                    ST_ACQUIRE: begin
                        if (acq_cnt_reg == CW'(ACQ_EDGES - 1)) begin
                            state_reg      <= ST_TRACK;
                            acq_cnt_reg    <= '0;
                            out_enable_reg <= 1'b1;
                        end else begin
                            acq_cnt_reg <= acq_cnt_reg + 1'b1;
                        end
                    end
                    ST_TRACK: begin
                        if (!good_edge) begin
                            stable_cnt_reg <= '0;
                        end else if (stable_cnt_reg == CW'(LOCK_EDGES - 1)) begin
                            state_reg      <= ST_LOCKED;
                            stable_cnt_reg <= '0;
                            bump_cnt_reg   <= '0;
                            miss_cnt_reg   <= '0;
                            locked_reg     <= 1'b1;
                        end else begin
                            stable_cnt_reg <= stable_cnt_reg + 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (good_edge) begin
                            miss_cnt_reg <= '0;
                            if (bump_cnt_reg == CW'(BUMP_EDGES - 1)) begin
                                bump_cnt_reg  <= '0;
                                freq_bump_reg <= 1'b1;
                            end else begin
                                bump_cnt_reg <= bump_cnt_reg + 1'b1;
                            end
                        end else begin
                            bump_cnt_reg <= '0;
                            if (miss_cnt_reg == CW'(MISS_LIMIT - 1)) begin
                                state_reg    <= ST_TRACK;
                                miss_cnt_reg <= '0;
                                locked_reg   <= 1'b0;
                                if (err_reg != 8'hFF)
                                    err_reg <= err_reg + 8'd1;
                            end else begin
                                miss_cnt_reg <= miss_cnt_reg + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end else if (wd_reg != '1) begin
                wd_reg <= wd_reg + 1'b1;
            end
        end
    end

    assign state      = state_reg;
    assign freq_reset = freq_reset_reg;
    assign freq_bump  = freq_bump_reg;
    assign out_enable = out_enable_reg;
    assign locked     = locked_reg;
    assign err_count  = err_reg;

endmodule

// File: tb/tb_clk_rec_lock_ctrl.sv
// Scoreboard bench for clk_rec_lock_ctrl: stimulus pushes expected outputs from a
// rule-level model, a monitor pops and compares them one cycle later.
module tb_clk_rec_lock_ctrl;

    localparam int TO  = 60;
    localparam int ACQ = 16;
    localparam int LCK = 8;
    localparam int BMP = 16;
    localparam int MSS = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        edge_valid = 1'b0;
    logic [31:0] interval = '0;
    logic [31:0] clk_freq = 32'd100;
    logic        freq_reset, freq_bump, out_enable, locked;
    logic [1:0]  state;
    logic [7:0]  err_count;

    clk_rec_lock_ctrl #(
        .CLK_LEN(32), .ACQ_EDGES(ACQ), .LOCK_EDGES(LCK),
        .BUMP_EDGES(BMP), .MISS_LIMIT(MSS), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .edge_valid(edge_valid), .interval(interval), .clk_freq(clk_freq),
        .freq_reset(freq_reset), .freq_bump(freq_bump), .out_enable(out_enable),
        .locked(locked), .state(state), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic       oe;
        logic       lk;
        logic       fr;
        logic       fb;
        logic [7:0] err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;

    // Reference model: phase and counters as plain integers.
    int m_phase, m_acq, m_stable, m_bump, m_miss, m_quiet, m_err;

    task automatic model_clear();
        m_phase = 0; m_acq = 0; m_stable = 0; m_bump = 0; m_miss = 0;
        m_quiet = 0; m_err = 0;
    endtask

    task automatic model_step(input bit s, input bit a, input bit ev,
                              input longint iv, input longint cf);
        bit fr, fb;
        exp_t e;
        fr = 0; fb = 0;
        if (a) begin
            m_phase = 0; m_acq = 0; m_stable = 0; m_bump = 0; m_miss = 0; m_quiet = 0;
        end else if (m_phase == 0) begin
            m_quiet = 0;
            if (s) begin m_phase = 1; fr = 1; end
        end else if (!ev && m_quiet + 1 >= TO) begin
            if (m_phase != 1 && m_err < 255) m_err++;
            m_phase = 1; fr = 1;
            m_acq = 0; m_stable = 0; m_bump = 0; m_miss = 0; m_quiet = 0;
        end else if (ev) begin
            bit good;
            good = (iv >= cf - cf / 8);
            m_quiet = 0;
            if (m_phase == 1) begin
                m_acq++;
                if (m_acq == ACQ) begin m_phase = 2; m_acq = 0; end
            end else if (m_phase == 2) begin
                m_stable = good ? m_stable + 1 : 0;
                if (m_stable == LCK) begin m_phase = 3; m_stable = 0; m_bump = 0; m_miss = 0; end
            end else begin
                if (good) begin
                    m_miss = 0; m_bump++;
                    if (m_bump == BMP) begin fb = 1; m_bump = 0; end
                end else begin
                    m_bump = 0; m_miss++;
                    if (m_miss == MSS) begin
                        m_phase = 2; m_miss = 0;
                        if (m_err < 255) m_err++;
                    end
                end
            end
        end else begin
            m_quiet++;
        end
        e.st  = 2'(m_phase);
        e.oe  = (m_phase >= 2);
        e.lk  = (m_phase == 3);
        e.fr  = fr;
        e.fb  = fb;
        e.err = 8'(m_err);
        q.push_back(e);
    endtask

    task automatic drive(input bit s, input bit a, input bit ev,
                         input logic [31:0] iv, input logic [31:0] cf);
        @(negedge clk);
        start = s; abort = a; edge_valid = ev; interval = iv; clk_freq = cf;
        model_step(s, a, ev, {32'b0, iv}, {32'b0, cf});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, $urandom, clk_freq);
    endtask

    task automatic edges(input int n, input logic [31:0] iv, input logic [31:0] cf);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 1, iv, cf);
            drive(0, 0, 0, $urandom, cf);
        end
    endtask

    task automatic check_now(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin @(posedge clk); n++; end
        #2;
        check_now("queue_drained", q.size(), 0);
    endtask

    // Monitor: every cycle the DUT presents a full output bundle.
    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() != 0) begin
                e = q.pop_front();
                a = {state, out_enable, locked, freq_reset, freq_bump, err_count};
                checks++;
                if (a === e) passes++;
                else $display("FAIL outputs cyc=%0d actual st=%0d oe=%0b lk=%0b fr=%0b fb=%0b err=%0d required st=%0d oe=%0b lk=%0b fr=%0b fb=%0b err=%0d",
                              cyc, a.st, a.oe, a.lk, a.fr, a.fb, a.err,
                              e.st, e.oe, e.lk, e.fr, e.fb, e.err);
            end
        end
    end

    initial begin
        int r;
        logic [31:0] cf, iv;
        model_clear();
        #3;
        check_now("reset_outputs", {state, out_enable, locked, freq_reset, freq_bump, err_count}, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Acquire, track, lock, bump.
        drive(1, 0, 0, 0, 100);
        edges(ACQ, 100, 100);
        edges(LCK, 100, 100);
        edges(BMP, 100, 100);
        // Boundary: 88 is good, 87 is bad; three bads drop lock.
        edges(3, 88, 100);
        edges(2, 87, 100);
        edges(1, 88, 100);
        edges(MSS, 50, 100);
        // Re-lock, then watchdog expiry from LOCKED.
        edges(LCK, 100, 100);
        idle(TO + 2);
        // Back to LOCKED, edge exactly on the expiry cycle.
        edges(ACQ, 100, 100);
        edges(LCK, 100, 100);
        idle(TO - 2);
        drive(0, 0, 1, 100, 100);
        idle(3);
        // abort + start together from TRACK.
        edges(MSS, 10, 100);
        drive(1, 1, 0, 0, 100);
        idle(2);
        drive(1, 0, 0, 0, 100);
        drive(1, 0, 0, 0, 100);

        // Randomized phase.
        cf = 32'd100;
        for (int i = 0; i < 20000; i++) begin
            r = $urandom_range(0, 999);
            if (r < 3) cf = (r == 0) ? $urandom : ((r == 1) ? 32'hFFFF_FFFF : 32'd100);
            r = $urandom_range(0, 99);
            if (r < 12) iv = cf - (cf >> 3) - 32'($urandom_range(1, 40));
            else if (r < 20) iv = cf - (cf >> 3);
            else iv = cf - (cf >> 3) + 32'($urandom_range(0, 60));
            if ($urandom_range(0, 999) == 0) idle($urandom_range(TO - 3, TO + 3));
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 799) == 0),
                  ($urandom_range(0, 2) == 0), iv, cf);
        end

        // Async reset while LOCKED.
        drive(0, 1, 0, 0, 100);
        drive(1, 0, 0, 0, 100);
        edges(ACQ, 100, 100);
        edges(LCK, 100, 100);
        drain();
        check_now("pre_reset_locked", {30'b0, state}, 3);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_now("async_rst_locked", {31'b0, locked}, 0);
        check_now("async_rst_oe", {31'b0, out_enable}, 0);
        check_now("async_rst_all", {state, out_enable, locked, freq_reset, freq_bump, err_count}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        idle(4);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
